adc_trigger_capture: RTL

- Capture stage directly downstream of the board clock generator.
- Clocked by the generator's 10 MHz ADC encode clock. Qualifies operation on the generator's DCM lock flag.
- On a start request, waits a programmable number of encode cycles, then captures a programmable number of ADC samples.
- Emits each sample as a tagged word over a valid/ready interface to the readout FIFO, and reports busy, done, error and dropped-sample status.

---
 rtl/adc_trigger_capture_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/adc_trigger_capture.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/adc_trigger_capture_pkg.sv
// Shared definitions for the ADC trigger/capture stage: FSM encoding and
// the bit positions of the FIRST/LAST tags in an output word.
package adc_trigger_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FIN     = 2'd3
    } state_t;

    // Output word layout is {FIRST, LAST, sample}.
    function automatic int first_bit(input int data_width);
        return data_width + 1;
    endfunction

    function automatic int last_bit(input int data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level signal.
// Output clears to 0 while reset is asserted.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/adc_trigger_capture.sv
// Triggered ADC capture: after START, waits DELAY encode cycles, captures SAMPLES
// words tagged {FIRST, LAST, sample} into a single-entry valid/ready output register.
module adc_trigger_capture
    import adc_trigger_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 14,
    parameter int CNT_WIDTH  = 16,
    parameter int DLY_WIDTH  = 8,
    parameter int LOST_WIDTH = 8
) (
    input  logic                    ADC_ENC,
    input  logic                    RST_N,
    input  logic                    LOCKED,
    input  logic [DATA_WIDTH-1:0]   ADC_IN,
    input  logic                    START,
    input  logic [CNT_WIDTH-1:0]    SAMPLES,
    input  logic [DLY_WIDTH-1:0]    DELAY,
    output logic [DATA_WIDTH+1:0]   DATA_OUT,
    output logic                    DATA_VALID,
    input  logic                    DATA_READY,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERR,
    output logic [LOST_WIDTH-1:0]   LOST_CNT,
    output logic [1:0]              STATE_DBG
);

    localparam int FIRST_BIT = first_bit(DATA_WIDTH);
    localparam int LAST_BIT  = last_bit(DATA_WIDTH);

    logic                  lock_s;
    logic [DATA_WIDTH-1:0] adc_q;

    state_t                state_q;
    logic [CNT_WIDTH-1:0]  n_q;
    logic [CNT_WIDTH-1:0]  k_q;
    logic [DLY_WIDTH-1:0]  d_q;
    logic [DATA_WIDTH+1:0] data_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
    logic [LOST_WIDTH-1:0] lost_q;
    logic [LOST_WIDTH-1:0] lost_d;

    logic [CNT_WIDTH-1:0]  last_idx;
    logic                  is_first;
    logic                  is_last;
    logic [DATA_WIDTH+1:0] word;
    logic                  capture_en;
    logic                  load_word;
    logic                  drop_word;

    sync_2ff u_lock_sync (
        .clk_i  (ADC_ENC),
        .rst_ni (RST_N),
        .d_i    (LOCKED),
        .q_o    (lock_s)
    );

    always_ff @(posedge ADC_ENC or negedge RST_N) begin
        if (!RST_N) begin
            adc_q <= '0;
        end else begin
            adc_q <= ADC_IN;
        end
    end

    always_comb begin
        last_idx   = n_q - CNT_WIDTH'(1);
        is_first   = (k_q == '0);
        is_last    = (k_q == last_idx);
        word       = '0;
        word[DATA_WIDTH-1:0] = adc_q;
        word[FIRST_BIT]      = is_first;
        word[LAST_BIT]       = is_last;
        // A word is only produced while lock holds; a lock loss aborts instead.
        capture_en = (state_q == ST_CAPTURE) && lock_s;
        load_word  = capture_en && (!valid_q || DATA_READY);
        drop_word  = capture_en && valid_q && !DATA_READY;
        lost_d     = (lost_q == '1) ? lost_q : lost_q + LOST_WIDTH'(1);
    end

    always_ff @(posedge ADC_ENC or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            d_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lost_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (lock_s) begin
                            n_q    <= SAMPLES;
                            d_q    <= DELAY;
                            k_q    <= '0;
                            err_q  <= 1'b0;
                            lost_q <= '0;
                            if (SAMPLES == '0) begin
                                state_q <= ST_FIN;
                                done_q  <= 1'b1;
                            end else if (DELAY == '0) begin
                                state_q <= ST_CAPTURE;
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= ST_WAIT;
                                busy_q  <= 1'b1;
                            end
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!lock_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        d_q <= d_q - DLY_WIDTH'(1);
                        if (d_q == DLY_WIDTH'(1)) begin
                            state_q <= ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (!lock_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        k_q <= k_q + CNT_WIDTH'(1);
                        if (is_last) begin
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Single-entry output register; a blocked word is counted, not queued.
            if (load_word) begin
                data_q  <= word;
                valid_q <= 1'b1;
            end else if (DATA_READY) begin
                valid_q <= 1'b0;
            end
            if (drop_word) begin
                lost_q <= lost_d;
            end
        end
    end

    assign DATA_OUT   = data_q;
    assign DATA_VALID = valid_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign ERR        = err_q;
    assign LOST_CNT   = lost_q;
    assign STATE_DBG  = state_q;

endmodule
